// File: rtl/stack_cpu_pkg.sv
// Shared definitions for the STACK_CPU operand stack: op encodings, fault codes
// and the default word width.
package stack_cpu_pkg;

  localparam int DEF_DATA_W = 32;

  // Codes 6 and 7 are unassigned and behave as NOP.
  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_BINOP = 3'd3,
    OP_DUP   = 3'd4,
    OP_SWAP  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    FLT_NONE  = 2'd0,
    FLT_UNDER = 2'd1,
    FLT_OVER  = 2'd2
  } flt_e;

endpackage

// File: rtl/stack_engine_if.sv
// Decode/ALU-facing bundle of the operand stack: op issue in, stack view and
// fault status out.
interface stack_engine_if #(
  parameter int DATA_W = 32,
  parameter int PTR_W  = 5
);

  logic              op_valid;
  logic [2:0]        op;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] result_data;
  logic [DATA_W-1:0] tos;
  logic [DATA_W-1:0] nos;
  logic [PTR_W-1:0]  depth;
  logic              empty;
  logic              full;
  logic              fault;
  logic              fault_sticky;
  logic [1:0]        fault_code;

  modport master (
    output op_valid, op, push_data, result_data,
    input  tos, nos, depth, empty, full, fault, fault_sticky, fault_code
  );

  modport slave (
    input  op_valid, op, push_data, result_data,
    output tos, nos, depth, empty, full, fault, fault_sticky, fault_code
  );

endinterface

// File: rtl/stack_spill_ram.sv
// Storage for stack entries below tos/nos: one synchronous write port and one
// asynchronous read port, no reset (contents are meaningless above depth).
module stack_spill_ram #(
  parameter int DATA_W  = 32,
  parameter int ENTRIES = 14,
  parameter int AW      = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [ENTRIES];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/stack_engine.sv
// Operand stack with the top two entries in registers and the rest spilled to
// a small RAM; illegal ops are dropped and reported through the fault outputs.
module stack_engine
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 5
) (
  input  logic           clock,
  input  logic           reset,
  stack_engine_if.slave  bus
);

  localparam int ENTRIES = DEPTH - 2;
  localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);
  localparam logic [PTR_W-1:0] TWO     = PTR_W'(2);
  localparam logic [PTR_W-1:0] THREE   = PTR_W'(3);

  if (DEPTH < 3 || (1 << PTR_W) <= DEPTH) begin : g_bad_params
    $error("stack_engine: DEPTH must be >= 3 and fit in PTR_W bits");
  end

  logic [DATA_W-1:0] tos_q, tos_d;
  logic [DATA_W-1:0] nos_q, nos_d;
  logic [PTR_W-1:0]  depth_q, depth_d;
  logic              fault_q, fault_d;
  logic              sticky_q, sticky_d;
  flt_e              code_q, code_d;
  flt_e              flt;

  logic              spill_we;
  logic [AW-1:0]     spill_waddr;
  logic [AW-1:0]     spill_raddr;
  logic [DATA_W-1:0] spill_rdata;
  logic [DATA_W-1:0] spill_fill;
  logic              is_full;
  logic              has_spill;

  assign is_full   = (depth_q == DEPTH_P);
  assign has_spill = (depth_q >= THREE);

  // Entry sp-2 receives the outgoing nos on a push; entry sp-3 refills nos on a pop.
  assign spill_waddr = AW'(depth_q - TWO);
  assign spill_raddr = has_spill ? AW'(depth_q - THREE) : '0;
  assign spill_fill  = has_spill ? spill_rdata : '0;

  stack_spill_ram #(
    .DATA_W  (DATA_W),
    .ENTRIES (ENTRIES),
    .AW      (AW)
  ) u_spill (
    .clock (clock),
    .we    (spill_we),
    .waddr (spill_waddr),
    .wdata (nos_q),
    .raddr (spill_raddr),
    .rdata (spill_rdata)
  );

  always_comb begin
    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    spill_we = 1'b0;
    flt      = FLT_NONE;

    if (bus.op_valid) begin
      case (op_e'(bus.op))
        OP_PUSH: begin
          if (is_full) begin
            flt = FLT_OVER;
          end else begin
            tos_d    = bus.push_data;
            nos_d    = tos_q;
            spill_we = (depth_q >= TWO);
            depth_d  = depth_q + ONE;
          end
        end
        OP_DUP: begin
          if (depth_q == '0) begin
            flt = FLT_UNDER;
          end else if (is_full) begin
            flt = FLT_OVER;
          end else begin
            nos_d    = tos_q;
            spill_we = (depth_q >= TWO);
            depth_d  = depth_q + ONE;
          end
        end
        OP_POP: begin
          if (depth_q == '0) begin
            flt = FLT_UNDER;
          end else begin
            tos_d   = nos_q;
            nos_d   = spill_fill;
            depth_d = depth_q - ONE;
          end
        end
        OP_BINOP: begin
          if (depth_q < TWO) begin
            flt = FLT_UNDER;
          end else begin
            tos_d   = bus.result_data;
            nos_d   = spill_fill;
            depth_d = depth_q - ONE;
          end
        end
        OP_SWAP: begin
          if (depth_q < TWO) begin
            flt = FLT_UNDER;
          end else begin
            tos_d = nos_q;
            nos_d = tos_q;
          end
        end
        default: ;
      endcase
    end

    fault_d  = (flt != FLT_NONE);
    sticky_d = sticky_q | fault_d;
    code_d   = fault_d ? flt : code_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tos_q    <= '0;
      nos_q    <= '0;
      depth_q  <= '0;
      fault_q  <= 1'b0;
      sticky_q <= 1'b0;
      code_q   <= FLT_NONE;
    end else begin
      tos_q    <= tos_d;
      nos_q    <= nos_d;
      depth_q  <= depth_d;
      fault_q  <= fault_d;
      sticky_q <= sticky_d;
      code_q   <= code_d;
    end
  end

  assign bus.tos          = tos_q;
  assign bus.nos          = nos_q;
  assign bus.depth        = depth_q;
  assign bus.empty        = (depth_q == '0);
  assign bus.full         = is_full;
  assign bus.fault        = fault_q;
  assign bus.fault_sticky = sticky_q;
  assign bus.fault_code   = code_q;

endmodule

// File: tb/tb_stack_engine.sv
// Drives a DEPTH=16 and a DEPTH=4 stack engine with the same op stream and
// compares both against a plain array-based stack model.
module tb_stack_engine;
  import stack_cpu_pkg::*;

  typedef struct packed {
    logic [31:0] tos;
    logic [31:0] nos;
    logic [4:0]  depth;
    logic        empty;
    logic        full;
    logic        fault;
    logic        sticky;
    logic [1:0]  code;
  } st_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  opr = 3'd0;
  logic [31:0] pdata = '0;
  logic [31:0] res [2];
  logic [31:0] res_salt = '0;

  int checks = 0;
  int errors = 0;

  int          dep [2] = '{16, 4};
  logic [31:0] mst [2][16];
  int          msp [2];
  bit          mflt [2];
  bit          mstk [2];
  logic [1:0]  mcode [2];

  st_t o_st [2];

  always #5 clock = ~clock;

  stack_engine_if #(.DATA_W(32), .PTR_W(5)) b16 ();
  stack_engine_if #(.DATA_W(32), .PTR_W(5)) b4 ();

  assign b16.op_valid    = valid;
  assign b16.op          = opr;
  assign b16.push_data   = pdata;
  assign b16.result_data = res[0];
  assign b4.op_valid     = valid;
  assign b4.op           = opr;
  assign b4.push_data    = pdata;
  assign b4.result_data  = res[1];

  stack_engine #(.DATA_W(32), .DEPTH(16), .PTR_W(5)) u_dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (b16.slave)
  );

  stack_engine #(.DATA_W(32), .DEPTH(4), .PTR_W(5)) u_dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (b4.slave)
  );

  assign o_st[0] = {b16.tos, b16.nos, b16.depth, b16.empty, b16.full,
                    b16.fault, b16.fault_sticky, b16.fault_code};
  assign o_st[1] = {b4.tos, b4.nos, b4.depth, b4.empty, b4.full,
                    b4.fault, b4.fault_sticky, b4.fault_code};

  function automatic logic [31:0] mtos(int k);
    return (msp[k] >= 1) ? mst[k][msp[k]-1] : 32'h0;
  endfunction

  function automatic logic [31:0] mnos(int k);
    return (msp[k] >= 2) ? mst[k][msp[k]-2] : 32'h0;
  endfunction

  function automatic st_t mexp(int k);
    st_t s;
    s.tos    = mtos(k);
    s.nos    = mnos(k);
    s.depth  = 5'(msp[k]);
    s.empty  = (msp[k] == 0);
    s.full   = (msp[k] == dep[k]);
    s.fault  = mflt[k];
    s.sticky = mstk[k];
    s.code   = mcode[k];
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      msp[k] = 0; mflt[k] = 0; mstk[k] = 0; mcode[k] = 2'd0;
    end
  endtask

  // Stack as an array with msp[k] entries; element msp-1 is the top.
  task automatic model_op(input int k, input bit v, input logic [2:0] o,
                          input logic [31:0] pd, input logic [31:0] rd);
    int sp;
    logic [1:0] f;
    logic [31:0] t;
    sp = msp[k];
    f = 2'd0;
    if (v) begin
      case (o)
        3'd1: if (sp < dep[k]) begin mst[k][sp] = pd; msp[k] = sp + 1; end else f = 2'd2;
        3'd2: if (sp >= 1) msp[k] = sp - 1; else f = 2'd1;
        3'd3: if (sp >= 2) begin mst[k][sp-2] = rd; msp[k] = sp - 1; end else f = 2'd1;
        3'd4: begin
          if (sp == 0) f = 2'd1;
          else if (sp == dep[k]) f = 2'd2;
          else begin mst[k][sp] = mst[k][sp-1]; msp[k] = sp + 1; end
        end
        3'd5: begin
          if (sp >= 2) begin
            t = mst[k][sp-1]; mst[k][sp-1] = mst[k][sp-2]; mst[k][sp-2] = t;
          end else f = 2'd1;
        end
        default: ;
      endcase
    end
    mflt[k] = (f != 2'd0);
    if (f != 2'd0) begin
      mstk[k] = 1'b1;
      mcode[k] = f;
    end
  endtask

  task automatic do_op(input bit v, input logic [2:0] o, input logic [31:0] pd, input bit rst);
    valid = v; opr = o; pdata = pd; reset = rst;
    for (int k = 0; k < 2; k++) res[k] = mtos(k) + mnos(k) + res_salt;
    @(posedge clock);
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) model_op(k, v, o, pd, res[k]);
    #1;
    reset = 1'b0; valid = 1'b0;
  endtask

  task automatic test_reset();
    st_t z;
    z = '0;
    z.empty = 1'b1;
    do_op(1'b1, OP_PUSH, 32'h99, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_st[k] !== z) begin
        errors++;
        $display("FAIL reset_state dut%0d: got %h want %h", k, o_st[k], z);
      end
    end
  endtask

  task automatic test_program();
    logic [31:0] pv [3] = '{32'h22, 32'h33, 32'h0};
    logic [2:0]  po [3] = '{OP_PUSH, OP_PUSH, OP_BINOP};
    do_op(1'b0, OP_NOP, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, po[i], pv[i], 1'b0);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_st[k].fault !== 1'b0) begin
          errors++;
          $display("FAIL program_fault dut%0d step%0d: got %b want 0", k, i, o_st[k].fault);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_st[k].tos, o_st[k].nos, o_st[k].depth} !== {32'h55, 32'h0, 5'd1}) begin
        errors++;
        $display("FAIL program_result dut%0d: got tos=%h nos=%h depth=%0d want 55/0/1",
                 k, o_st[k].tos, o_st[k].nos, o_st[k].depth);
      end
    end
  endtask

  task automatic test_spill();
    do_op(1'b0, OP_NOP, 0, 1'b1);
    for (int i = 1; i <= 4; i++) do_op(1'b1, OP_PUSH, 32'(i), 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_st[k].tos, o_st[k].nos, o_st[k].depth} !== {32'h4, 32'h3, 5'd4}) begin
        errors++;
        $display("FAIL spill_push dut%0d: got tos=%h nos=%h depth=%0d want 4/3/4",
                 k, o_st[k].tos, o_st[k].nos, o_st[k].depth);
      end
    end
    do_op(1'b1, OP_POP, 0, 1'b0);
    do_op(1'b1, OP_POP, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_st[k].tos, o_st[k].nos, o_st[k].depth} !== {32'h2, 32'h1, 5'd2}) begin
        errors++;
        $display("FAIL spill_pop dut%0d: got tos=%h nos=%h depth=%0d want 2/1/2",
                 k, o_st[k].tos, o_st[k].nos, o_st[k].depth);
      end
    end
  endtask

  task automatic test_overflow();
    do_op(1'b0, OP_NOP, 0, 1'b1);
    for (int i = 0; i < 5; i++) do_op(1'b1, OP_PUSH, 32'hA + 32'(i), 1'b0);
    checks++;
    if ({o_st[1].tos, o_st[1].depth, o_st[1].full, o_st[1].fault, o_st[1].sticky, o_st[1].code}
        !== {32'hD, 5'd4, 1'b1, 1'b1, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL overflow_dut4: got %h want tos=d depth=4 full fault sticky code=2", o_st[1]);
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_st[k] !== mexp(k)) begin
        errors++;
        $display("FAIL overflow_model dut%0d: got %h want %h", k, o_st[k], mexp(k));
      end
    end
    do_op(1'b0, OP_NOP, 0, 1'b0);
    checks++;
    if ({o_st[1].fault, o_st[1].sticky, o_st[1].code} !== {1'b0, 1'b1, 2'd2}) begin
      errors++;
      $display("FAIL overflow_pulse dut4: got fault=%b sticky=%b code=%0d want 0/1/2",
               o_st[1].fault, o_st[1].sticky, o_st[1].code);
    end
  endtask

  task automatic test_underflow();
    do_op(1'b0, OP_NOP, 0, 1'b1);
    do_op(1'b1, OP_POP, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_st[k].depth, o_st[k].fault, o_st[k].code} !== {5'd0, 1'b1, 2'd1}) begin
        errors++;
        $display("FAIL underflow_pop dut%0d: got depth=%0d fault=%b code=%0d want 0/1/1",
                 k, o_st[k].depth, o_st[k].fault, o_st[k].code);
      end
    end
    do_op(1'b1, OP_PUSH, 32'h1, 1'b0);
    do_op(1'b1, OP_BINOP, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_st[k].tos, o_st[k].depth, o_st[k].fault, o_st[k].code} !== {32'h1, 5'd1, 1'b1, 2'd1}) begin
        errors++;
        $display("FAIL underflow_binop dut%0d: got tos=%h depth=%0d fault=%b code=%0d want 1/1/1/1",
                 k, o_st[k].tos, o_st[k].depth, o_st[k].fault, o_st[k].code);
      end
    end
  endtask

  task automatic test_swap_dup();
    do_op(1'b0, OP_NOP, 0, 1'b1);
    do_op(1'b1, OP_PUSH, 32'h5, 1'b0);
    do_op(1'b1, OP_PUSH, 32'h6, 1'b0);
    do_op(1'b1, OP_SWAP, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_st[k].tos, o_st[k].nos} !== {32'h5, 32'h6}) begin
        errors++;
        $display("FAIL swap dut%0d: got tos=%h nos=%h want 5/6", k, o_st[k].tos, o_st[k].nos);
      end
    end
    do_op(1'b1, OP_DUP, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_st[k].tos, o_st[k].nos, o_st[k].depth} !== {32'h5, 32'h5, 5'd3}) begin
        errors++;
        $display("FAIL dup dut%0d: got tos=%h nos=%h depth=%0d want 5/5/3",
                 k, o_st[k].tos, o_st[k].nos, o_st[k].depth);
      end
    end
  endtask

  task automatic test_reset_mid();
    st_t z;
    z = '0;
    z.empty = 1'b1;
    do_op(1'b0, OP_NOP, 0, 1'b1);
    do_op(1'b1, OP_POP, 0, 1'b0);
    for (int i = 1; i <= 3; i++) do_op(1'b1, OP_PUSH, 32'(i), 1'b0);
    do_op(1'b1, OP_PUSH, 32'h77, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (o_st[k] !== z) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got %h want %h", k, o_st[k], z);
      end
    end
    do_op(1'b1, OP_POP, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({o_st[k].fault, o_st[k].sticky, o_st[k].code} !== {1'b1, 1'b1, 2'd1}) begin
        errors++;
        $display("FAIL reset_mid_pop dut%0d: got fault=%b sticky=%b code=%0d want 1/1/1",
                 k, o_st[k].fault, o_st[k].sticky, o_st[k].code);
      end
    end
  endtask

  task automatic test_random();
    int  r;
    bit  v;
    bit  rs;
    logic [2:0] o;
    do_op(1'b0, OP_NOP, 0, 1'b1);
    for (int i = 0; i < 800; i++) begin
      r  = int'($urandom_range(0, 99));
      v  = (r < 90);
      rs = ($urandom_range(0, 79) == 0);
      // Push-heavy mix so the deep DUT actually reaches its spill entries.
      r = int'($urandom_range(0, 9));
      o = (r < 4) ? 3'd1 : (r < 9) ? 3'($urandom_range(2, 5)) : 3'($urandom_range(6, 7));
      res_salt = $urandom;
      do_op(v, o, $urandom, rs);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (o_st[k] !== mexp(k)) begin
          errors++;
          $display("FAIL random dut%0d cycle%0d: got %h want %h", k, i, o_st[k], mexp(k));
        end
      end
    end
    res_salt = '0;
  endtask

  initial begin
    res[0] = '0;
    res[1] = '0;
    model_reset();
    test_reset();
    test_program();
    test_spill();
    test_overflow();
    test_underflow();
    test_swap_dup();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
